// File: rtl/ticks_timer_sched.sv
// Millisecond tick counter with four countdown timer channels behind a 3-state command FSM.
// Define TICKS_SCHED_PERIODIC_EN to make armed channels auto-reload on expiry.
module ticks_timer_sched #(
  parameter int unsigned CLK_DIV = 100000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_port,
  input  logic [1:0]  op,
  input  logic [1:0]  ch,
  input  logic [15:0] delay,
  output logic        done_port,
  output logic [31:0] out1,
  output logic [3:0]  expired,
  output logic        irq
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_DIV - 1);

  localparam logic [1:0] OP_READ   = 2'd0;
  localparam logic [1:0] OP_ARM    = 2'd1;
  localparam logic [1:0] OP_CANCEL = 2'd2;
  localparam logic [1:0] OP_CLEAR  = 2'd3;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t state, state_next;

  logic [PW-1:0] prescaler;
  logic          ms_tick;
  logic [31:0]   ticks;
  logic [1:0]    op_q;
  logic [1:0]    ch_q;
  logic [15:0]   delay_q;
  logic [15:0]   remaining [4];
  logic [3:0]    active;
  logic          exec;
  logic          chan_cmd;
  logic [3:0]    cmd_hit;

  assign ms_tick  = (prescaler == PRE_MAX);
  assign exec     = (state == EXEC);
  assign chan_cmd = exec && ((op_q == OP_ARM) || (op_q == OP_CANCEL));
  assign irq      = |expired;

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    done_port  = 1'b0;
    case (state)
      IDLE: if (start_port) state_next = EXEC;
      EXEC: state_next = DONE;
      DONE: begin
        state_next = IDLE;
        done_port  = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      op_q    <= OP_READ;
      ch_q    <= 2'd0;
      delay_q <= 16'd0;
    end else if ((state == IDLE) && start_port) begin
      op_q    <= op;
      ch_q    <= ch;
      delay_q <= delay;
    end
  end

  // CLEAR_TICKS at the execution edge wins over a coincident ms_tick.
  always_ff @(posedge clock) begin
    if (!reset) begin
      prescaler <= '0;
      ticks     <= 32'd0;
    end else if (exec && (op_q == OP_CLEAR)) begin
      prescaler <= '0;
      ticks     <= 32'd0;
    end else if (ms_tick) begin
      prescaler <= '0;
      ticks     <= ticks + 32'd1;
    end else begin
      prescaler <= prescaler + PW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      out1 <= 32'd0;
    end else if (exec) begin
      case (op_q)
        OP_ARM, OP_CANCEL: out1 <= {16'd0, remaining[ch_q]};
        default:           out1 <= ticks;
      endcase
    end
  end

  always_comb begin
    cmd_hit = 4'd0;
    for (int i = 0; i < 4; i++) cmd_hit[i] = chan_cmd && (ch_q == 2'(i));
  end

`ifdef TICKS_SCHED_PERIODIC_EN
  logic [15:0] reload [4];

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) reload[i] <= 16'd0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (cmd_hit[i]) reload[i] <= (op_q == OP_ARM) ? delay_q : 16'd0;
    end
  end
`endif

  // A command on a channel overrides that channel's decrement in the same cycle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) remaining[i] <= 16'd0;
      active  <= 4'd0;
      expired <= 4'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (cmd_hit[i]) begin
          if (op_q == OP_ARM) begin
            remaining[i] <= delay_q;
            active[i]    <= (delay_q != 16'd0);
            expired[i]   <= (delay_q == 16'd0);
          end else begin
            remaining[i] <= 16'd0;
            active[i]    <= 1'b0;
            expired[i]   <= 1'b0;
          end
        end else if (ms_tick && active[i]) begin
          if (remaining[i] <= 16'd1) begin
            expired[i] <= 1'b1;
`ifdef TICKS_SCHED_PERIODIC_EN
            remaining[i] <= reload[i];
`else
            remaining[i] <= 16'd0;
            active[i]    <= 1'b0;
`endif
          end else begin
            remaining[i] <= remaining[i] - 16'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ticks_timer_sched.sv
// Bench for ticks_timer_sched: directed and random commands checked every cycle against a
// deadline-based reference model (timers tracked as absolute ms-tick deadlines).
module tb_ticks_timer_sched;

  localparam int CLK_DIV = 4;
`ifdef TICKS_SCHED_PERIODIC_EN
  localparam bit PERIODIC = 1'b1;
`else
  localparam bit PERIODIC = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start_port = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [1:0]  ch = 2'd0;
  logic [15:0] delay = 16'd0;
  logic        done_port;
  logic [31:0] out1;
  logic [3:0]  expired;
  logic        irq;

  ticks_timer_sched #(.CLK_DIV(CLK_DIV)) dut (
    .clock(clock), .reset(reset), .start_port(start_port), .op(op), .ch(ch),
    .delay(delay), .done_port(done_port), .out1(out1), .expired(expired), .irq(irq)
  );

  always #5 clock = ~clock;

  // Reference model: ms ticks counted globally; a channel is a deadline on that count.
  int          m_cyc;
  longint      m_g;
  logic [31:0] m_ticks;
  int          m_stage;
  logic [1:0]  m_op, m_ch;
  logic [15:0] m_delay;
  logic [31:0] m_out;
  longint      m_deadline [4];
  longint      m_reload [4];
  bit          m_active [4];
  bit          m_expired [4];

  int n_checks = 0;
  int n_pass = 0;
  int n_fail = 0;

  function automatic void model_reset();
    m_cyc = 0; m_g = 0; m_ticks = 32'd0; m_stage = 0;
    m_op = 2'd0; m_ch = 2'd0; m_delay = 16'd0; m_out = 32'd0;
    for (int n = 0; n < 4; n++) begin
      m_deadline[n] = 0; m_reload[n] = 0; m_active[n] = 0; m_expired[n] = 0;
    end
  endfunction

  function automatic logic [15:0] rem_of(int n, longint g);
    return m_active[n] ? 16'(m_deadline[n] - g) : 16'd0;
  endfunction

  function automatic logic [3:0] m_exp_vec();
    logic [3:0] v;
    for (int n = 0; n < 4; n++) v[n] = m_expired[n];
    return v;
  endfunction

  function automatic void model_edge();
    bit     tick, exec, chan;
    longint g0, g1;
    int     c;
    if (!reset) begin
      model_reset();
      return;
    end
    tick = (m_cyc == CLK_DIV - 1);
    exec = (m_stage == 1);
    chan = exec && (m_op == 2'd1 || m_op == 2'd2);
    c    = int'(m_ch);
    g0   = m_g;
    g1   = m_g + (tick ? 1 : 0);
    if (exec) m_out = chan ? {16'h0, rem_of(c, g0)} : m_ticks;
    for (int n = 0; n < 4; n++) begin
      if (tick && m_active[n] && !(chan && c == n) && m_deadline[n] == g1) begin
        m_expired[n] = 1;
        if (PERIODIC) m_deadline[n] = m_deadline[n] + m_reload[n];
        else          m_active[n] = 0;
      end
    end
    if (chan && m_op == 2'd1) begin
      m_reload[c] = longint'(m_delay);
      if (m_delay == 16'd0) begin
        m_active[c] = 0; m_expired[c] = 1;
      end else begin
        m_active[c] = 1; m_expired[c] = 0; m_deadline[c] = g1 + longint'(m_delay);
      end
    end else if (chan) begin
      m_active[c] = 0; m_expired[c] = 0; m_reload[c] = 0;
    end
    if (exec && m_op == 2'd3) begin
      m_ticks = 32'd0; m_cyc = 0;
    end else begin
      if (tick) m_ticks = m_ticks + 32'd1;
      m_cyc = tick ? 0 : m_cyc + 1;
    end
    m_g = g1;
    case (m_stage)
      0: if (start_port) begin
        m_stage = 1; m_op = op; m_ch = ch; m_delay = delay;
      end
      1: m_stage = 2;
      default: m_stage = 0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_output();
    check("done_port", {31'd0, done_port}, {31'd0, m_stage == 2});
    check("out1", out1, m_out);
    check("expired", {28'd0, expired}, {28'd0, m_exp_vec()});
    check("irq", {31'd0, irq}, {31'd0, |m_exp_vec()});
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    check_output();
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  task automatic apply_stimulus(input logic [1:0] o, input logic [1:0] c, input logic [15:0] d);
    start_port = 1'b1; op = o; ch = c; delay = d;
    step();
    start_port = 1'b0;
    step();
    check("cmd_done_pulse", {31'd0, done_port}, 32'd1);
    step();
  endtask

  // Wait until the next edge lands on the given prescaler phase, bounded.
  task automatic wait_phase(input int target);
    for (int i = 0; i < 3 * CLK_DIV; i++) begin
      if (m_cyc == target) return;
      step();
    end
    check("wait_phase_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int pulses;
    logic prev_done;
    model_reset();
    $display("[TB] reset");
    run(3);
    check("reset_out1", out1, 32'd0);
    check("reset_expired", {28'd0, expired}, 32'd0);
    reset = 1'b1;

    $display("[TB] idle then READ_TICKS");
    run(40);
    apply_stimulus(2'd0, 2'd0, 16'd0);
    check("read_after_idle_range", {31'd0, (out1 >= 32'd9 && out1 <= 32'd11)}, 32'd1);

    $display("[TB] ARM ch2 delay3");
    apply_stimulus(2'd1, 2'd2, 16'd3);
    run(3 * CLK_DIV);
    check("arm_expired_ch2", {28'd0, expired}, 32'h4);
    check("arm_irq", {31'd0, irq}, 32'd1);
    apply_stimulus(2'd2, 2'd2, 16'd0);
    check("cancel_out1", out1, 32'd0);
    check("cancel_expired", {28'd0, expired}, 32'd0);

    $display("[TB] ARM ch1 delay0");
    apply_stimulus(2'd1, 2'd1, 16'd0);
    check("arm0_expired", {28'd0, expired}, 32'h2);
    check("arm0_out1", out1, 32'd0);

    $display("[TB] ticks wrap");
    force dut.ticks = 32'hFFFF_FFFF;
    #1;
    release dut.ticks;
    m_ticks = 32'hFFFF_FFFF;
    wait_phase(CLK_DIV - 1);
    step();
    apply_stimulus(2'd0, 2'd0, 16'd0);
    check("wrap_read", out1, 32'd0);
    run(2 * CLK_DIV + 1);
    wait_phase(CLK_DIV - 2);
    apply_stimulus(2'd3, 2'd0, 16'd0);
    apply_stimulus(2'd0, 2'd0, 16'd0);
    check("clear_on_tick_read", out1, 32'd0);

    $display("[TB] start held high");
    pulses = 0;
    prev_done = 1'b0;
    start_port = 1'b1; op = 2'd0;
    for (int i = 0; i < 15; i++) begin
      step();
      check("no_back_to_back", {31'd0, prev_done & done_port}, 32'd0);
      prev_done = done_port;
      if (done_port) pulses++;
    end
    start_port = 1'b0;
    run(3);
    check("held_pulse_count", pulses, 32'd5);

    $display("[TB] random commands");
    for (int k = 0; k < 40; k++) begin
      apply_stimulus(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 16'($urandom_range(0, 6)));
      for (int g = 0; g < int'($urandom_range(0, 6)); g++) begin
        start_port = ($urandom_range(0, 3) == 0);
        op = 2'($urandom_range(0, 3)); ch = 2'($urandom_range(0, 3));
        delay = 16'($urandom_range(0, 4));
        step();
      end
      start_port = 1'b0;
      run(3);
    end

    $display("[TB] reset mid-command");
    start_port = 1'b1; op = 2'd1; ch = 2'd3; delay = 16'd2;
    step();
    start_port = 1'b0; reset = 1'b0;
    step();
    check("abort_no_done", {31'd0, done_port}, 32'd0);
    start_port = 1'b1;
    step();
    reset = 1'b1; start_port = 1'b0;
    step();
    check("abort_done_low", {31'd0, done_port}, 32'd0);
    check("abort_expired", {28'd0, expired}, 32'd0);

    $display("[TB] ARM ch0 delay2 expiry behaviour");
    apply_stimulus(2'd1, 2'd0, 16'd2);
    run(3 * CLK_DIV);
    check("delay2_expired", {31'd0, expired[0]}, 32'd1);
    apply_stimulus(2'd1, 2'd0, 16'd5);
    if (!PERIODIC) check("oneshot_remaining", out1, 32'd0);
    else check("periodic_remaining_nonzero", {31'd0, out1 != 32'd0}, 32'd1);
    run(2 * CLK_DIV);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
